ram_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly upstream of single_port_ram (64 x 8, one shared address, synchronous write and synchronous registered read).
- Accepts a valid/ready byte stream, time-multiplexes the single RAM port between writes and reads, and presents the data in order on a valid/ready output stream.
- Turns the bare RAM into a 64-entry stream buffer.

---
 rtl/ram_fifo_ctrl.sv | 92 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO controller for a 64 x 8 single-port RAM with a registered read port.
// The one RAM port is shared between writes and reads by round-robin arbitration.
module ram_fifo_ctrl #(
   parameter int DW = 8,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] ram_data,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   input  logic [DW-1:0] ram_q,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_t;

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   level_reg;
   logic          rd_pending_reg;
   logic          out_valid_reg;
   logic [DW-1:0] out_data_reg;
   grant_t        last_grant_reg;

   logic wr_req;
   logic rd_req;
   logic grant_wr;
   logic grant_rd;

   assign full  = (level_reg == DEPTH);
   assign empty = (level_reg == '0);

   // rst_n gating keeps the RAM port quiet while reset is held.
   assign wr_req = rst_n && in_valid && !full;
   assign rd_req = rst_n && !empty && !rd_pending_reg && (!out_valid_reg || out_ready);

   assign grant_wr = wr_req && (!rd_req || (last_grant_reg == GRANT_RD));
   assign grant_rd = rd_req && !grant_wr;

   assign ram_we    = grant_wr;
   assign ram_addr  = grant_wr ? wr_ptr_reg : rd_ptr_reg;
   assign ram_data  = in_data;
   assign in_ready  = grant_wr;
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign level     = level_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         level_reg      <= '0;
         rd_pending_reg <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         last_grant_reg <= GRANT_RD;
      end else begin
         if (grant_wr) begin
            wr_ptr_reg     <= wr_ptr_reg + AW'(1);
            level_reg      <= level_reg + (AW+1)'(1);
            last_grant_reg <= GRANT_WR;
         end else if (grant_rd) begin
            rd_ptr_reg     <= rd_ptr_reg + AW'(1);
            level_reg      <= level_reg - (AW+1)'(1);
            last_grant_reg <= GRANT_RD;
         end
         rd_pending_reg <= grant_rd;
         // A landing read beats a same-edge handshake; rd_req gating keeps this safe.
         if (rd_pending_reg) begin
            out_data_reg  <= ram_q;
            out_valid_reg <= 1'b1;
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 64 x 8 read-first RAM attached.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] ram_data;
   logic [5:0] ram_addr;
   logic       ram_we;
   logic [7:0] ram_q;
   logic [6:0] level;
   logic       full;
   logic       empty;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem [64];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   ram_fifo_ctrl #(.DW(8), .AW(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
      .level(level), .full(full), .empty(empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, check combinational and registered outputs 1 time unit later.
   task automatic cyc(input string tag, input logic iv, input logic [7:0] d, input logic ordy,
                      input logic e_we, input logic [5:0] e_addr, input logic e_ir,
                      input logic e_ov, input logic [7:0] e_od, input logic [6:0] e_lvl);
      @(negedge clk);
      in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      chk({tag, ".ram_we"}, 32'(ram_we), 32'(e_we));
      chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(e_addr));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_ir));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
      chk({tag, ".out_data"}, 32'(out_data), 32'(e_od));
      chk({tag, ".level"}, 32'(level), 32'(e_lvl));
      chk({tag, ".ram_data"}, 32'(ram_data), 32'(d));
      $display("step %s: iv=%0b d=%02h ordy=%0b we=%0b addr=%0d ir=%0b ov=%0b od=%02h lvl=%0d",
               tag, iv, d, ordy, ram_we, ram_addr, in_ready, out_valid, out_data, level);
   endtask

   initial begin
      int sent;
      int rcvd;
      int n;

      // Reset with a request pending: nothing may be accepted.
      in_valid = 1'b1; in_data = 8'hAA;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.ram_we", 32'(ram_we), 32'd0);
      chk("rst.empty", 32'(empty), 32'd1);
      chk("rst.full", 32'(full), 32'd0);
      chk("rst.level", 32'(level), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b1;

      // Three bytes with the output side stalled.
      cyc("p1c1",  1, 8'h01, 0, 1, 6'd0, 1, 0, 8'h00, 7'd0);
      cyc("p1c2",  1, 8'h02, 0, 0, 6'd0, 0, 0, 8'h00, 7'd1);
      cyc("p1c3",  1, 8'h02, 0, 1, 6'd1, 1, 0, 8'h00, 7'd0);
      cyc("p1c4",  1, 8'h03, 0, 1, 6'd2, 1, 1, 8'h01, 7'd1);
      cyc("p1c5",  0, 8'h00, 0, 0, 6'd1, 0, 1, 8'h01, 7'd2);
      cyc("p1c6",  0, 8'h00, 0, 0, 6'd1, 0, 1, 8'h01, 7'd2);
      chk("p1.empty", 32'(empty), 32'd0);
      // Drain in order.
      cyc("p2c7",  0, 8'h00, 1, 0, 6'd1, 0, 1, 8'h01, 7'd2);
      cyc("p2c8",  0, 8'h00, 1, 0, 6'd2, 0, 0, 8'h01, 7'd1);
      cyc("p2c9",  0, 8'h00, 1, 0, 6'd2, 0, 1, 8'h02, 7'd1);
      cyc("p2c10", 0, 8'h00, 1, 0, 6'd3, 0, 0, 8'h02, 7'd0);
      cyc("p2c11", 0, 8'h00, 1, 0, 6'd3, 0, 1, 8'h03, 7'd0);
      cyc("p2c12", 0, 8'h00, 1, 0, 6'd3, 0, 0, 8'h03, 7'd0);
      chk("p2.empty", 32'(empty), 32'd1);

      // Fill: one byte goes to the output register, 64 more fill the RAM.
      cyc("p3f1", 1, 8'h00, 0, 1, 6'd3, 1, 0, 8'h03, 7'd0);
      cyc("p3f2", 1, 8'h01, 0, 0, 6'd3, 0, 0, 8'h03, 7'd1);
      for (int k = 1; k <= 64; k++) begin
         cyc("p3fill", 1, 8'(k), 0, 1, 6'((3 + k) % 64), 1, (k > 1),
             (k > 1) ? 8'h00 : 8'h03, 7'(k - 1));
         chk("p3fill.full", 32'(full), 32'd0);
      end
      cyc("p3full", 1, 8'h41, 0, 0, 6'd4, 0, 1, 8'h00, 7'd64);
      chk("p3full.full", 32'(full), 32'd1);
      chk("p3full.empty", 32'(empty), 32'd0);
      cyc("p3pop",  1, 8'h41, 1, 0, 6'd4, 0, 1, 8'h00, 7'd64);
      cyc("p3refill", 1, 8'h41, 1, 1, 6'd4, 1, 0, 8'h00, 7'd63);
      cyc("p3rd",   1, 8'h42, 1, 0, 6'd5, 0, 1, 8'h01, 7'd64);

      // Reset the cycle after a read grant, with the read still in flight.
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", 32'(out_valid), 32'd0);
      chk("midrst.level", 32'(level), 32'd0);
      chk("midrst.empty", 32'(empty), 32'd1);
      chk("midrst.full", 32'(full), 32'd0);
      chk("midrst.ram_we", 32'(ram_we), 32'd0);
      chk("midrst.in_ready", 32'(in_ready), 32'd0);
      $display("step midrst: ov=%0b lvl=%0d we=%0b", out_valid, level, ram_we);
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b1;

      // Stream 70 bytes through while draining; alternation and wrap are checked on the fly.
      sent = 0; rcvd = 0; n = 0;
      while (rcvd < 70 && n < 600) begin
         @(negedge clk);
         in_valid = (sent < 70); in_data = 8'(sent); out_ready = 1'b1;
         #1;
         if (n < 8) chk("p4.alt_in_ready", 32'(in_ready), 32'((n % 2) == 0));
         if (in_ready) begin
            chk("p4.wr_addr", 32'(ram_addr), 32'(sent % 64));
            chk("p4.wr_we", 32'(ram_we), 32'd1);
            $display("wr byte %02h addr %0d", in_data, ram_addr);
            sent++;
         end
         if (out_valid) begin
            chk("p4.rd_data", 32'(out_data), 32'(rcvd));
            $display("rd byte %02h", out_data);
            rcvd++;
         end
         n++;
      end
      chk("p4.rcvd", 32'(rcvd), 32'd70);
      @(negedge clk); in_valid = 1'b0; #1;
      chk("p4.empty", 32'(empty), 32'd1);
      chk("p4.level", 32'(level), 32'd0);
      chk("p4.out_valid", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
